code_prog_ctrl: RTL and testbench
=================================

# code_prog_ctrl

Sequencer that owns all writes into code storage. It accepts MMIO-issued commands (unlock, program word, set write-protect) and runs the multi-cycle program pulse on the code-memory write port. Every program operation is gated by the sticky write-protect state from the code WP latch. It sits between the MMIO control-register decoder and the code storage array, and drives the latch's set input.

## Interface
Parameters:
- ADDR_W, 16, code-storage word address width
- DATA_W, 32, code word width
- PROG_CYCLES, 8, cycles `mem_we_o` is held per program operation; legal range 1..255
- UNLOCK_KEY, 32'hC0DE_5A5A, key value for UNLOCK, compared against `cmd_data_i[31:0]`; DATA_W ≥ 32

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_op_i  in  2  0=UNLOCK, 1=PROGRAM, 2=WP_SET, 3=reserved
- cmd_addr_i  in  ADDR_W  PROGRAM target address
- cmd_data_i  in  DATA_W  PROGRAM data, or key for UNLOCK
- wp_i  in  1  write-protect state from the latch
- wp_set_o  out  1  one-cycle pulse to the latch set input
- mem_we_o  out  1  code-storage write enable
- mem_addr_o  out  ADDR_W  write address, held stable for the whole operation
- mem_wdata_o  out  DATA_W  write data, held stable for the whole operation
- mem_rdata_i  in  DATA_W  read-back of `mem_addr_o`, valid the cycle after the address is stable
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse when any accepted command completes
- err_o  out  2  result of the last completed command: 0=OK, 1=WP, 2=NOT_ARMED/BADKEY/BADOP, 3=ABORT/VERIFY

## Operation
- States: IDLE, PROG, VERIFY, DONE. `cmd_ready_o` = (state==IDLE).
- Armed flag:
  - Set by an accepted UNLOCK whose key matches and while `wp_i`=0.
  - Cleared by every other accepted command, including reserved op 3.
  - Cleared on any cycle where `wp_i`=1.
- UNLOCK completion:
  - Wrong key: err=2.
  - UNLOCK while `wp_i`=1: err=1, armed flag stays clear.
  - Otherwise err=0.
  - Goes to DONE; the armed-flag update happens on the accept edge.
- PROGRAM accepted:
  - `wp_i`=1 → err=1, goes to DONE, no memory write.
  - Not armed → err=2, goes to DONE, no memory write.
  - Otherwise latch addr and data, load the counter with PROG_CYCLES, go to PROG.
- PROG:
  - `mem_we_o`=1. The counter decrements each cycle.
  - At counter==1, leave PROG: go to VERIFY if CODE_PROG_VERIFY_EN is defined, else go to DONE with err=0.
- `wp_i` rising while in PROG:
  - `mem_we_o` drops on the next cycle; go to DONE with err=3.
  - The partial write is the software's responsibility.
- VERIFY:
  - One cycle with `mem_we_o`=0.
  - Compare `mem_rdata_i` against the latched data: mismatch → err=3, match → err=0.
  - Go to DONE.
- WP_SET: `wp_set_o` pulses on the cycle after accept, err=0, go to DONE. It is legal even if `wp_i` is already 1.
- Reserved op 3: err=2, go to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE. `err_o` updates on the cycle DONE is entered and holds until the next DONE.
- `busy_o` = (state != IDLE).

## Timing
- Reset values: state IDLE, armed 0, counter 0. Output values in reset: cmd_ready_o=1, wp_set_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0.
- PROGRAM latency from the accept edge to the `done_o` pulse: PROG_CYCLES+1 cycles, or PROG_CYCLES+2 with verify.
- Rejected commands and UNLOCK/WP_SET: `done_o` one cycle after accept. The next command can be accepted two cycles after the previous accept.
- `mem_we_o` asserts on the cycle after accept and is high for exactly PROG_CYCLES cycles, unless aborted.
- Reset mid-PROG: `mem_we_o` deasserts asynchronously and all state returns to reset values.
- A command offered while busy is stalled, not dropped; `cmd_valid_i` may stay high.

## Configuration
- CODE_PROG_VERIFY_EN:
  - Defined: the VERIFY state exists and a mismatch reports err=3.
  - Undefined: VERIFY is removed, `mem_rdata_i` is unused, PROG goes straight to DONE with err=0.

## Structure
- Shared package `code_prog_pkg` holds:
  - the op enum (UNLOCK/PROGRAM/WP_SET/RSVD)
  - the state enum
  - the err codes
  - the default UNLOCK_KEY constant
- No sub-module: one FSM, one counter and the armed flag, all in this module.

## Test plan
- UNLOCK key C0DE_5A5A, then PROGRAM addr 0x0010 data 0xDEADBEEF with PROG_CYCLES=8 → `mem_we_o` high 8 cycles with that addr/data, `done_o` pulse, err=0.
- PROGRAM without a prior UNLOCK → no `mem_we_o`, `done_o` one cycle after accept, err=2. Also UNLOCK key 0x12345678 → err=2, and a following PROGRAM gives err=2.
- WP_SET → `wp_set_o` pulses once. Tie `wp_i`=1, then UNLOCK plus PROGRAM → err=1 for both, no write.
- Raise `wp_i` on the 3rd PROG cycle → `mem_we_o` low on the next cycle, err=3, armed cleared.
- With CODE_PROG_VERIFY_EN defined, return `mem_rdata_i`=0xDEADBEEE → err=3. Return matching data → err=0.
- Assert `rst_n`=0 mid-PROG → `mem_we_o`=0 immediately, `busy_o`=0 and `cmd_ready_o`=1 after release, and PROGRAM without a fresh UNLOCK gives err=2.

Source files
------------

// File: rtl/code_prog_pkg.sv
// code_prog_pkg: shared op, state and error encodings for code_prog_ctrl
package code_prog_pkg;
    typedef enum logic [1:0] {OP_UNLOCK, OP_PROGRAM, OP_WP_SET, OP_RSVD} op_e;
    typedef enum logic [1:0] {S_IDLE, S_PROG, S_VERIFY, S_DONE} state_e;
    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_WP    = 2'd1;
    localparam logic [1:0] ERR_ARM   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;
    localparam logic [31:0] DEFAULT_UNLOCK_KEY = 32'hC0DE_5A5A;
endpackage

// File: rtl/code_prog_ctrl.sv
// code_prog_ctrl: sequences unlock/program/write-protect commands into code storage.
// Define CODE_PROG_VERIFY_EN to add a read-back VERIFY cycle after each program pulse.
module code_prog_ctrl
    import code_prog_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          DATA_W      = 32,
    parameter int          PROG_CYCLES = 8,
    parameter logic [31:0] UNLOCK_KEY  = DEFAULT_UNLOCK_KEY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic              wp_i,
    output logic              wp_set_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o
);
    state_e            r_state;
    logic              r_armed;
    logic              r_wp_set;
    logic              r_we;
    logic              r_done;
    logic [7:0]        r_cnt;
    logic [1:0]        r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    op_e               w_op;
    logic              w_key_ok;

    assign w_op        = op_e'(cmd_op_i);
    assign w_key_ok    = cmd_data_i[31:0] == UNLOCK_KEY;
    assign cmd_ready_o = r_state == S_IDLE;
    assign busy_o      = r_state != S_IDLE;
    assign wp_set_o    = r_wp_set;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign done_o      = r_done;
    assign err_o       = r_err;

`ifndef CODE_PROG_VERIFY_EN
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_armed  <= 1'b0;
            r_wp_set <= 1'b0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= 8'd0;
            r_err    <= ERR_OK;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_wp_set <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid_i) begin
                    r_armed <= 1'b0;
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    case (w_op)
                        OP_UNLOCK: begin
                            r_err   <= !w_key_ok ? ERR_ARM : (wp_i ? ERR_WP : ERR_OK);
                            r_armed <= w_key_ok && !wp_i;
                        end
                        OP_PROGRAM: begin
                            if (wp_i) r_err <= ERR_WP;
                            else if (!r_armed) r_err <= ERR_ARM;
                            else begin
                                r_state <= S_PROG;
                                r_done  <= 1'b0;
                                r_we    <= 1'b1;
                                r_cnt   <= 8'(PROG_CYCLES);
                                r_addr  <= cmd_addr_i;
                                r_wdata <= cmd_data_i;
                            end
                        end
                        OP_WP_SET: begin
                            r_wp_set <= 1'b1;
                            r_err    <= ERR_OK;
                        end
                        default: r_err <= ERR_ARM;
                    endcase
                end
                S_PROG: begin
                    r_cnt <= r_cnt - 8'd1;
                    // a write-protect arriving mid-pulse wins over normal completion
                    if (wp_i) begin
                        r_we    <= 1'b0;
                        r_err   <= ERR_ABORT;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (r_cnt == 8'd1) begin
                        r_we <= 1'b0;
`ifdef CODE_PROG_VERIFY_EN
                        r_state <= S_VERIFY;
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= ERR_OK;
`endif
                    end
                end
`ifdef CODE_PROG_VERIFY_EN
                S_VERIFY: begin
                    r_err   <= (mem_rdata_i == r_wdata) ? ERR_OK : ERR_ABORT;
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
            if (wp_i) r_armed <= 1'b0;
        end
    end
endmodule

// File: tb/tb_code_prog_ctrl.sv
// tb_code_prog_ctrl: randomized commands checked every cycle against a transaction-level timeline model.
module tb_code_prog_ctrl;
    localparam int P = 8;
    localparam logic [31:0] KEY = 32'hC0DE_5A5A;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cmd_valid_i = 0;
    logic [1:0]  cmd_op_i = 0;
    logic [15:0] cmd_addr_i = 0;
    logic [31:0] cmd_data_i = 0;
    logic        wp_i = 0;
    logic [31:0] mem_rdata_i = 0;
    logic        cmd_ready_o, wp_set_o, mem_we_o, busy_o, done_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  err_o;

    code_prog_ctrl #(.ADDR_W(16), .DATA_W(32), .PROG_CYCLES(P), .UNLOCK_KEY(KEY)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .wp_i(wp_i),
        .wp_set_o(wp_set_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          c;
        bit          busy, we, done, wps;
        logic [1:0]  err;
        logic [15:0] addr;
        logic [31:0] wdata;
    } exp_t;
    exp_t q[$];

    int vectors = 0, miscompares = 0;
    int we_cnt = 0, wps_cnt = 0;
    bit          m_armed = 0;
    logic [1:0]  m_err = 0;
    logic [15:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    int          m_free = 0;
    logic [1:0]  l_err = 0;
    logic [15:0] l_addr = 0;
    logic [31:0] l_wdata = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input bit busy, input bit we, input bit done, input bit wps, input logic [1:0] err);
        exp_t e;
        e.c = c; e.busy = busy; e.we = we; e.done = done; e.wps = wps;
        e.err = err; e.addr = m_addr; e.wdata = m_wdata;
        q.push_back(e);
    endtask

    // per-cycle check: outputs follow the queued timeline, or idle defaults between commands
    always @(negedge clk) begin
        exp_t e;
        if (mem_we_o) we_cnt++;
        if (wp_set_o) wps_cnt++;
        if (!rst_n) begin
            l_err = 0; l_addr = 0; l_wdata = 0;
        end
        if (rst_n && q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            l_err = e.err; l_addr = e.addr; l_wdata = e.wdata;
        end else begin
            e.c = cyc; e.busy = 0; e.we = 0; e.done = 0; e.wps = 0;
            e.err = l_err; e.addr = l_addr; e.wdata = l_wdata;
        end
        chk("ready", cmd_ready_o, !e.busy);
        chk("busy", busy_o, e.busy);
        chk("mem_we", mem_we_o, e.we);
        chk("done", done_o, e.done);
        chk("wp_set", wp_set_o, e.wps);
        chk("err", err_o, e.err);
        chk("mem_addr", mem_addr_o, e.addr);
        chk("mem_wdata", mem_wdata_o, e.wdata);
    end

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                          input bit wp, input int abort_at, input bit corrupt, input bit early);
        int k, n;
        bit ok;
        logic [1:0] e;
        while (cyc < m_free - (early ? 1 : 0)) step();
        cmd_valid_i = 1; cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = data; wp_i = wp;
        mem_rdata_i = corrupt ? data ^ 32'h1 : data;
        k = (cyc > m_free ? cyc : m_free) + 1;
        ok = op == 2'd1 && !wp && m_armed;
        if (op == 2'd0) e = (data != KEY) ? 2'd2 : (wp ? 2'd1 : 2'd0);
        else if (op == 2'd1) e = wp ? 2'd1 : 2'd2;
        else if (op == 2'd2) e = 2'd0;
        else e = 2'd2;
        m_armed = op == 2'd0 && data == KEY && !wp;
        if (!ok) begin
            push(k, 1, 0, 1, op == 2'd2, e);
            n = 1;
        end else begin
            m_addr = addr; m_wdata = data;
            n = abort_at > 0 ? abort_at : P;
            for (int i = 0; i < n; i++) push(k + i, 1, 1, 0, 0, m_err);
            if (abort_at > 0) e = 2'd3;
            else begin
`ifdef CODE_PROG_VERIFY_EN
                push(k + n, 1, 0, 0, 0, m_err);
                n++;
                e = corrupt ? 2'd3 : 2'd0;
`else
                e = 2'd0;
`endif
            end
            push(k + n, 1, 0, 1, 0, e);
            n++;
        end
        m_err = e;
        m_free = k + n;
        while (cyc < k) step();
        cmd_valid_i = 0; cmd_op_i = 2'($urandom); cmd_addr_i = 16'($urandom); cmd_data_i = $urandom;
        if (ok && abort_at > 0) begin
            while (cyc < k + abort_at - 1) step();
            wp_i = 1;
            m_armed = 0;
        end
    endtask

    task automatic wait_idle();
        while (cyc < m_free) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        rst_n = 1;
        m_free = cyc;
        // directed: unlock then a full program pulse
        do_cmd(2'd0, 16'h0, KEY, 0, 0, 0, 0);
        wait_idle();
        chk("lit_unlock_ok", err_o, 2'd0);
        we_cnt = 0;
        do_cmd(2'd1, 16'h0010, 32'hDEADBEEF, 0, 0, 0, 0);
        wait_idle();
        chk("lit_prog_err", err_o, 2'd0);
        chk("lit_prog_we_cycles", we_cnt, 8);
        chk("lit_prog_addr", mem_addr_o, 16'h0010);
        chk("lit_prog_data", mem_wdata_o, 32'hDEADBEEF);
        we_cnt = 0;
        do_cmd(2'd1, 16'h0011, 32'h1, 0, 0, 0, 0);
        wait_idle();
        chk("lit_unarmed_err", err_o, 2'd2);
        chk("lit_unarmed_no_we", we_cnt, 0);
        do_cmd(2'd0, 16'h0, 32'h12345678, 0, 0, 0, 0);
        wait_idle();
        chk("lit_badkey_err", err_o, 2'd2);
        do_cmd(2'd1, 16'h0012, 32'h2, 0, 0, 0, 0);
        wait_idle();
        chk("lit_badkey_prog_err", err_o, 2'd2);
        wps_cnt = 0;
        do_cmd(2'd2, 16'h0, 32'h0, 0, 0, 0, 0);
        wait_idle();
        chk("lit_wpset_pulses", wps_cnt, 1);
        chk("lit_wpset_err", err_o, 2'd0);
        do_cmd(2'd0, 16'h0, KEY, 1, 0, 0, 0);
        wait_idle();
        chk("lit_wp_unlock_err", err_o, 2'd1);
        we_cnt = 0;
        do_cmd(2'd1, 16'h0013, 32'h3, 1, 0, 0, 0);
        wait_idle();
        chk("lit_wp_prog_err", err_o, 2'd1);
        chk("lit_wp_prog_no_we", we_cnt, 0);
        // directed: abort on the third program cycle
        do_cmd(2'd0, 16'h0, KEY, 0, 0, 0, 0);
        we_cnt = 0;
        do_cmd(2'd1, 16'h0030, 32'hA5A5_0001, 0, 3, 0, 0);
        wait_idle();
        chk("lit_abort_err", err_o, 2'd3);
        chk("lit_abort_we_cycles", we_cnt, 3);
        do_cmd(2'd1, 16'h0031, 32'h4, 0, 0, 0, 0);
        wait_idle();
        chk("lit_after_abort_err", err_o, 2'd2);
`ifdef CODE_PROG_VERIFY_EN
        do_cmd(2'd0, 16'h0, KEY, 0, 0, 0, 0);
        do_cmd(2'd1, 16'h0040, 32'hDEADBEEF, 0, 0, 1, 0);
        wait_idle();
        chk("lit_verify_bad", err_o, 2'd3);
        do_cmd(2'd0, 16'h0, KEY, 0, 0, 0, 0);
        do_cmd(2'd1, 16'h0041, 32'hDEADBEEF, 0, 0, 0, 0);
        wait_idle();
        chk("lit_verify_good", err_o, 2'd0);
`endif
        for (int t = 0; t < 300; t++) begin
            logic [1:0] op;
            op = (m_armed && $urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom);
            repeat ($urandom_range(0, 2)) step();
            do_cmd(op, 16'($urandom), ($urandom_range(0, 3) == 0) ? $urandom : KEY,
                   $urandom_range(0, 9) == 0,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, P - 1)) : 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end
        wait_idle();
        // directed: reset in the middle of a program pulse
        do_cmd(2'd0, 16'h0, KEY, 0, 0, 0, 0);
        do_cmd(2'd1, 16'h0020, 32'h1234_5678, 0, 0, 0, 0);
        repeat (3) step();
        chk("lit_mid_prog_we", mem_we_o, 1'b1);
        rst_n = 0;
        #1;
        chk("lit_rst_we_async", mem_we_o, 1'b0);
        q.delete();
        m_armed = 0; m_err = 0; m_addr = 0; m_wdata = 0;
        repeat (2) step();
        rst_n = 1;
        m_free = cyc;
        step();
        chk("lit_rst_ready", cmd_ready_o, 1'b1);
        chk("lit_rst_busy", busy_o, 1'b0);
        do_cmd(2'd1, 16'h0021, 32'h5, 0, 0, 0, 0);
        wait_idle();
        chk("lit_rst_prog_err", err_o, 2'd2);
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
